// File: rtl/alu_share_arb_pkg.sv
// Shared types for the ALU sharing arbiter: data widths, ALU op codes, FSM states.
package alu_share_arb_pkg;

    localparam int unsigned XLEN         = 32;
    localparam int unsigned SHIFT_AMOUNT = 5;

    // ALU op codes; 4'b1010..4'b1111 are undefined and produce zero
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_EXEC = 2'b01,
        ARB_RESP = 2'b10
    } alu_arb_state_t;

endpackage

// File: rtl/alu_share_arb_alu.sv
// Combinational integer ALU shared by the arbiter; undefined ops yield zero.
module alu
    import alu_share_arb_pkg::*;
(
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] result_o,
    output logic            zero_o
);

    logic [SHIFT_AMOUNT-1:0] shamt;
    logic                    lt_s;
    logic                    lt_u;

    assign shamt = b_i[SHIFT_AMOUNT-1:0];
    assign lt_s  = $signed(a_i) < $signed(b_i);
    assign lt_u  = a_i < b_i;

    // Operation select
    always_comb begin
        result_o = '0;
        case (op_i)
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
            ALU_SLT:  result_o = {{(XLEN-1){1'b0}}, lt_s};
            ALU_SLTU: result_o = {{(XLEN-1){1'b0}}, lt_u};
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_AND:  result_o = a_i & b_i;
            default:  result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/alu_share_arb_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module rr_pick #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] last_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_idx_o,
    output logic                 any_o
);

    localparam int unsigned RW = $clog2(N);

    logic [RW-1:0] cand;

    // Scan last+1, last+2, ... modulo N and take the first requester found
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_o     = 1'b0;
        cand      = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = RW'((32'(last_i) + k) % N);
            if (!any_o && req_i[cand]) begin
                any_o     = 1'b1;
                gnt_idx_o = cand;
            end
        end
        if (any_o) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one ALU between NUM_REQ requesters with a single
// response slot. Optional build macro: ALU_ARB_FAST_EN (drops the EXEC state,
// feeding the ALU straight from the granted requester).
module alu_share_arb
    import alu_share_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0][XLEN-1:0]  req_a,
    input  logic [NUM_REQ-1:0][XLEN-1:0]  req_b,
    input  logic [NUM_REQ-1:0][3:0]       req_op,
    output logic [NUM_REQ-1:0]            rsp_valid,
    input  logic [NUM_REQ-1:0]            rsp_ready,
    output logic [XLEN-1:0]               rsp_result,
    output logic                          rsp_zero,
    output logic                          busy
);

    localparam int unsigned   RW       = $clog2(NUM_REQ);
    localparam logic [RW-1:0] LAST_RST = RW'(NUM_REQ - 1);

    alu_arb_state_t  state_q,  state_d;
    logic [RW-1:0]   owner_q,  owner_d;
    logic [RW-1:0]   rr_last_q, rr_last_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q,   zero_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [RW-1:0]      pick_idx;
    logic               pick_any;

    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic            alu_zero;

    rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req_i     (req_valid),
        .last_i    (rr_last_q),
        .gnt_o     (pick_gnt),
        .gnt_idx_o (pick_idx),
        .any_o     (pick_any)
    );

`ifdef ALU_ARB_FAST_EN
    // Feed the ALU directly from the requester being granted this cycle
    assign alu_op = req_op[pick_idx];
    assign alu_a  = req_a[pick_idx];
    assign alu_b  = req_b[pick_idx];
`else
    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] a_q,  a_d;
    logic [XLEN-1:0] b_q,  b_d;

    // Operand capture registers, loaded at the request handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            op_q <= op_d;
            a_q  <= a_d;
            b_q  <= b_d;
        end
    end

    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;
`endif

    alu u_alu (
        .op_i     (alu_op),
        .a_i      (alu_a),
        .b_i      (alu_b),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    // Next-state logic: grant in IDLE, evaluate in EXEC, hold result in RESP
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        result_d  = result_q;
        zero_d    = zero_q;
`ifndef ALU_ARB_FAST_EN
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
`endif
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    owner_d   = pick_idx;
                    rr_last_d = pick_idx;
`ifdef ALU_ARB_FAST_EN
                    result_d  = alu_result;
                    zero_d    = alu_zero;
                    state_d   = ARB_RESP;
`else
                    op_d      = req_op[pick_idx];
                    a_d       = req_a[pick_idx];
                    b_d       = req_b[pick_idx];
                    state_d   = ARB_EXEC;
`endif
                end
            end
            ARB_EXEC: begin
                result_d = alu_result;
                zero_d   = alu_zero;
                state_d  = ARB_RESP;
            end
            ARB_RESP: begin
                // Only the owning requester can release the response slot
                if (rsp_ready[owner_q]) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // State and result registers; reset discards any in-flight op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB_IDLE;
            owner_q   <= '0;
            rr_last_q <= LAST_RST;
            result_q  <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
        end
    end

    // Handshake and response decode from registered state
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (rst_n && (state_q == ARB_IDLE)) begin
            req_ready = pick_gnt;
        end
        if (state_q == ARB_RESP) begin
            rsp_valid[owner_q] = 1'b1;
        end
    end

    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign busy       = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios plus a randomized
// run against a transaction-level reference model.
module tb_alu_share_arb;
    import alu_share_arb_pkg::*;

    localparam int NR = 2;
`ifdef ALU_ARB_FAST_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NR-1:0]           req_valid;
    logic [NR-1:0]           req_ready;
    logic [NR-1:0][31:0]     req_a;
    logic [NR-1:0][31:0]     req_b;
    logic [NR-1:0][3:0]      req_op;
    logic [NR-1:0]           rsp_valid;
    logic [NR-1:0]           rsp_ready;
    logic [31:0]             rsp_result;
    logic                    rsp_zero;
    logic                    busy;

    int checks = 0;
    int errors = 0;

    alu_share_arb #(.NUM_REQ(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference ALU from arithmetic definitions on 64-bit integers
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint ua, ub, sa, sb;
        int sh;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(ub % 32);
        case (op)
            ALU_ADD:  return 32'(ua + ub);
            ALU_SUB:  return 32'(ua - ub);
            ALU_SLL:  return 32'(ua << sh);
            ALU_SRL:  return 32'(ua >> sh);
            ALU_SRA:  return 32'(sa >>> sh);
            ALU_SLT:  return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU: return (ua < ub) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            default:  return 32'd0;
        endcase
    endfunction

    // Round-robin rule: first valid index after 'last', wrapping; -1 if none
    function automatic int ref_pick(input logic [NR-1:0] v, input int last);
        int i;
        for (int k = 1; k <= NR; k++) begin
            i = (last + k) % NR;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 3))
            0:       return 32'($urandom_range(0, 4));
            1:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 2));
            default: return $urandom();
        endcase
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one op on lane idx, wait for grant, then count cycles to rsp_valid
    task automatic issue(input int idx, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, output bit ok, output int lat);
        ok  = 1'b0;
        lat = -1;
        @(negedge clk);
        req_valid[idx] = 1'b1;
        req_op[idx]    = op;
        req_a[idx]     = a;
        req_b[idx]     = b;
        #1;
        for (int c = 0; c < 30 && !ok; c++) begin
            if (req_ready[idx]) ok = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        if (!ok) begin
            req_valid[idx] = 1'b0;
            return;
        end
        @(negedge clk);
        req_valid[idx] = 1'b0;
        #1;
        for (int c = 1; c <= 10; c++) begin
            if (rsp_valid[idx]) begin
                lat = c;
                return;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '1;
        rsp_ready = '0;
        #1;
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", rsp_result); end
        checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", rsp_zero); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        req_valid = '0;
        apply_reset();
    endtask

    task automatic test_single();
        bit ok;
        int lat;
        apply_reset();
        issue(0, ALU_ADD, 32'd5, 32'd7, ok, lat);
        checks++; if (!ok || lat !== LAT) begin errors++; $display("FAIL single_latency: got ok=%0d lat=%0d expected lat=%0d", ok, lat, LAT); end
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid: got %b expected 01", rsp_valid); end
        checks++; if (rsp_result !== 32'd12) begin errors++; $display("FAIL single_result: got %0d expected 12", rsp_result); end
        checks++; if (rsp_zero !== 1'b0) begin errors++; $display("FAIL single_zero: got %b expected 0", rsp_zero); end
        rsp_ready = 2'b01;
        @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== '0) begin errors++; $display("FAIL single_release: got busy=%b rsp_valid=%b expected 0/00", busy, rsp_valid); end
        rsp_ready = '0;
    endtask

    task automatic test_contention();
        int exp_seq[4];
        int ng, last_cyc, g, n_sub;
        logic [31:0] a0, b0, exp0;
        exp_seq = '{0, 1, 0, 1};
        ng = 0; last_cyc = -1; n_sub = 0;
        apply_reset();
        a0 = $urandom(); b0 = $urandom();
        exp0 = ref_alu(ALU_ADD, a0, b0);
        req_op[0] = ALU_ADD; req_a[0] = a0; req_b[0] = b0;
        req_op[1] = ALU_SUB; req_a[1] = 32'd3; req_b[1] = 32'd3;
        req_valid = '1;
        rsp_ready = '1;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            #1;
            if (req_ready !== '0) begin
                g = req_ready[1] ? 1 : 0;
                checks++; if (g !== exp_seq[ng]) begin errors++; $display("FAIL contention_grant%0d: got %0d expected %0d", ng, g, exp_seq[ng]); end
                if (last_cyc >= 0) begin
                    checks++; if (c - last_cyc !== LAT + 1) begin errors++; $display("FAIL contention_spacing%0d: got %0d expected %0d", ng, c - last_cyc, LAT + 1); end
                end
                last_cyc = c;
                ng++;
            end
            if (rsp_valid === 2'b01) begin
                checks++; if (rsp_result !== exp0 || rsp_zero !== (exp0 == 0)) begin errors++; $display("FAIL contention_add: got %h/%b expected %h/%b", rsp_result, rsp_zero, exp0, exp0 == 0); end
            end else if (rsp_valid === 2'b10) begin
                n_sub++;
                checks++; if (rsp_result !== 32'd0 || rsp_zero !== 1'b1) begin errors++; $display("FAIL contention_sub_zero: got %h/%b expected 0/1", rsp_result, rsp_zero); end
            end
            @(negedge clk);
        end
        checks++; if (ng !== 4 || n_sub < 1) begin errors++; $display("FAIL contention_count: got grants=%0d sub_rsps=%0d expected 4 and >=1", ng, n_sub); end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        apply_reset();
        issue(1, ALU_SRA, 32'h8000_0000, 32'd4, ok, lat);
        checks++; if (!ok || lat !== LAT) begin errors++; $display("FAIL bp_latency: got ok=%0d lat=%0d expected lat=%0d", ok, lat, LAT); end
        req_valid[0] = 1'b1;
        req_op[0] = ALU_ADD; req_a[0] = 32'd1; req_b[0] = 32'd1;
        #1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'hF800_0000 || req_ready !== '0) begin
                errors++; $display("FAIL bp_hold%0d: got rsp_valid=%b result=%h req_ready=%b expected 10/f8000000/00", k, rsp_valid, rsp_result, req_ready);
            end
            if (k < 4) begin
                @(negedge clk);
                #1;
            end
        end
        @(negedge clk);
        rsp_ready = 2'b10;
        #1;
        checks++; if (rsp_valid !== 2'b10 || rsp_result !== 32'hF800_0000) begin errors++; $display("FAIL bp_accept_cycle: got %b/%h expected 10/f8000000", rsp_valid, rsp_result); end
        @(negedge clk);
        rsp_ready = '0;
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== '0 || req_ready !== 2'b01) begin
            errors++; $display("FAIL bp_idle: got busy=%b rsp_valid=%b req_ready=%b expected 0/00/01", busy, rsp_valid, req_ready);
        end
        req_valid = '0;
    endtask

    task automatic test_ops();
        logic [3:0]  t_op[5];
        logic [31:0] t_a[5];
        logic [31:0] t_b[5];
        logic [31:0] t_r[5];
        bit ok;
        int lat;
        t_op = '{ALU_SLT, ALU_SLTU, ALU_SLL, 4'b1111, ALU_ADD};
        t_a  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'h1234_5678, 32'hFFFF_FFFF};
        t_b  = '{32'd1, 32'd1, 32'd33, 32'h9ABC_DEF0, 32'd1};
        t_r  = '{32'd1, 32'd0, 32'd2, 32'd0, 32'd0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            issue(0, t_op[i], t_a[i], t_b[i], ok, lat);
            checks++; if (!ok || lat !== LAT || rsp_result !== t_r[i] || rsp_zero !== (t_r[i] == 0)) begin
                errors++; $display("FAIL ops%0d op=%b: got ok=%0d lat=%0d result=%h zero=%b expected lat=%0d result=%h zero=%b",
                                   i, t_op[i], ok, lat, rsp_result, rsp_zero, LAT, t_r[i], t_r[i] == 0);
            end
            rsp_ready = 2'b01;
            @(negedge clk);
            rsp_ready = '0;
        end
    endtask

    task automatic test_midop_reset();
        apply_reset();
        req_valid[0] = 1'b1;
        req_op[0] = ALU_ADD; req_a[0] = 32'd1; req_b[0] = 32'd2;
        @(negedge clk);
        req_valid = '0;
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
        rst_n     = 1'b0;
        req_valid = '1;
        #1;
        checks++; if (req_ready !== '0 || rsp_valid !== '0 || rsp_result !== 32'd0 || rsp_zero !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs: got ready=%b rsp_valid=%b result=%h zero=%b busy=%b expected all 0",
                               req_ready, rsp_valid, rsp_result, rsp_zero, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL midrst_first_grant: got %b expected 01", req_ready); end
        req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== '0 || busy !== 1'b0) begin errors++; $display("FAIL midrst_no_rsp%0d: got rsp_valid=%b busy=%b expected 00/0", k, rsp_valid, busy); end
        end
    endtask

    task automatic test_wrong_owner();
        bit ok;
        int lat;
        logic [31:0] a, b, exp;
        apply_reset();
        a = $urandom(); b = $urandom();
        exp = ref_alu(ALU_XOR, a, b);
        issue(1, ALU_XOR, a, b, ok, lat);
        checks++; if (!ok || lat !== LAT) begin errors++; $display("FAIL wrong_owner_latency: got ok=%0d lat=%0d expected lat=%0d", ok, lat, LAT); end
        rsp_ready = 2'b01;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checks++; if (rsp_valid !== 2'b10 || rsp_result !== exp || busy !== 1'b1) begin
                errors++; $display("FAIL wrong_owner_hold%0d: got %b/%h/%b expected 10/%h/1", k, rsp_valid, rsp_result, busy, exp);
            end
        end
        rsp_ready = 2'b10;
        @(negedge clk);
        rsp_ready = '0;
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== '0) begin errors++; $display("FAIL wrong_owner_release: got busy=%b rsp_valid=%b expected 0/00", busy, rsp_valid); end
    endtask

    task automatic test_random();
        bit m_busy;
        int m_wait, m_owner, m_last, g;
        logic [31:0] m_res;
        logic [NR-1:0] prev_ready, exp_ready, exp_rsp;
        bit exp_busy;
        apply_reset();
        m_busy = 1'b0; m_wait = 0; m_owner = 0; m_last = NR - 1; m_res = '0;
        prev_ready = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (!(req_valid[i] && !prev_ready[i])) begin
                    req_valid[i] = ($urandom_range(0, 9) < 6);
                    req_op[i]    = 4'($urandom_range(0, 15));
                    req_a[i]     = rnd_operand();
                    req_b[i]     = rnd_operand();
                end
                rsp_ready[i] = ($urandom_range(0, 1) == 1);
            end
            #1;
            exp_ready = '0;
            exp_rsp   = '0;
            g = -1;
            if (!m_busy) begin
                exp_busy = 1'b0;
                g = ref_pick(req_valid, m_last);
                if (g >= 0) exp_ready[g] = 1'b1;
            end else begin
                exp_busy = 1'b1;
                if (m_wait > 0) m_wait--;
                if (m_wait == 0) exp_rsp[m_owner] = 1'b1;
            end
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_ready c%0d: got %b expected %b", cyc, req_ready, exp_ready); end
            checks++; if (rsp_valid !== exp_rsp) begin errors++; $display("FAIL rand_rsp_valid c%0d: got %b expected %b", cyc, rsp_valid, exp_rsp); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rand_busy c%0d: got %b expected %b", cyc, busy, exp_busy); end
            if (exp_rsp !== '0) begin
                checks++; if (rsp_result !== m_res || rsp_zero !== (m_res == 0)) begin
                    errors++; $display("FAIL rand_result c%0d: got %h/%b expected %h/%b", cyc, rsp_result, rsp_zero, m_res, m_res == 0);
                end
            end
            if (g >= 0) begin
                m_busy = 1'b1; m_wait = LAT; m_owner = g; m_last = g;
                m_res = ref_alu(req_op[g], req_a[g], req_b[g]);
            end else if (m_busy && m_wait == 0 && rsp_ready[m_owner]) begin
                m_busy = 1'b0;
            end
            prev_ready = req_ready;
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = '0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
        req_a = '0; req_b = '0; req_op = '0;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_ops();
        test_midop_reset();
        test_wrong_owner();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
